uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Oversampling UART receiver with a buffered read interface. It is the receiving end for the team's `Uart_tr` serial stream on boards where the transmitter and receiver sit on separate clocks and line noise matters. The block samples `rx` at 16x baud with 3-sample majority voting and checks framing. Good bytes are queued in a first-word-fall-through FIFO so a slow consumer can drain them at its own pace.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD, 115200, line rate; oversample divider DIV = CLK_FREQ/(16*BAUD), integer, must be ≥ 2
- FIFO_DEPTH, 8, byte entries, power of two, ≥ 2

- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low
- rx  input  1  serial line, idle high, asynchronous to clk
- rd_en  input  1  pop request; ignored when rd_valid = 0
- rd_data  output  8  FIFO head byte, valid while rd_valid = 1
- rd_valid  output  1  FIFO not empty
- fifo_full  output  1  FIFO holds FIFO_DEPTH entries
- rx_done  output  1  one-cycle pulse when a byte is pushed
- frame_err  output  1  one-cycle pulse when the stop bit samples 0
- parity_err  output  1  one-cycle pulse on a parity mismatch (tied 0 without UART_RX_PARITY_EN)
- overrun  output  1  sticky: a good byte arrived while the FIFO was full

## Operation
- `rx` passes through a 2-FF synchronizer, initialised to 1 at reset; all logic uses the synchronized value.
- Tick counter: free-running 0..DIV-1 while the FSM is not IDLE. It produces a 1-cycle `tick` at DIV-1 and is cleared when a start bit is detected.
- A sample counter of 0..15 counts ticks within each bit. The bit value is the majority of samples 7, 8 and 9.
- FSM states:
  - IDLE: leave on a synchronized falling edge; go to START.
  - START: at sample 15, a majority of 1 is a false start and returns to IDLE with no flags. Otherwise go to DATA.
  - DATA: 8 bits received LSB first into a shift register; after bit 7 go to PARITY if enabled, else STOP.
  - PARITY: even parity over the 8 data bits plus the parity bit; after sample 15 go to STOP.
  - STOP: the decision is made at sample 9 (majority complete), then return to IDLE immediately.
    - Stop = 0: pulse frame_err; the byte is discarded.
    - Parity mismatch: pulse parity_err; the byte is discarded.
    - Otherwise the byte is pushed and rx_done pulses.
- FIFO: FIFO_DEPTH entries with log2(FIFO_DEPTH)+1-bit wrap-around pointers.
  - Full when the pointers differ only in the MSB; empty when they are equal.
- Push while full and no pop in the same cycle: the byte is dropped, overrun is set, and rx_done does not pulse.
- Push and pop in the same cycle while full: both proceed, the count is unchanged, and no overrun is raised.
- Push and pop in the same cycle while empty: only the push takes effect, because rd_valid was 0.
- overrun clears on the first accepted pop after it was set.
- Reset at any time: FSM to IDLE, FIFO emptied, partial frame discarded.

## Timing
- Reset values: rd_data 0, rd_valid 0, fifo_full 0, rx_done 0, frame_err 0, parity_err 0, overrun 0.
- Start detection latency: 2 synchronizer cycles after the `rx` fall.
- Push, rx_done, frame_err and parity_err all occur in the cycle after the tick that completes stop-bit sample 9.
- rd_valid and updated rd_data are visible 1 cycle after the push; fifo_full updates on the same edge.
- Pop: when rd_en=1 and rd_valid=1 at an edge, the next head byte (or rd_valid=0) appears after that edge.
- Back-to-back frames: a start edge arriving during stop samples 10..15 is accepted, because the FSM is already back in IDLE.

## Configuration
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state present; frame is 11 bits (start, 8 data, even parity, stop).
  - parity_err is live.
- Undefined:
  - PARITY state and parity logic are removed; frame is 10 bits.
  - parity_err is driven constant 0.

## Structure
- Package `uart_pkg` holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP;
  - constants OVERSAMPLE=16, SAMPLE_MID=8, DATA_BITS=8;
  - a function computing DIV from CLK_FREQ and BAUD.
- One sub-module `uart_sync_fifo` (parameter DEPTH, WIDTH=8; push/pop/full/empty with FWFT output). The receiver FSM, synchronizer and tick generator stay in the top module.

## Test plan
All scenarios use CLK_FREQ=7_372_800 and BAUD=115200 (DIV=4, 64 clk per bit).
- Send 0xA5, parity even if enabled → rx_done pulse once, rd_valid=1, rd_data=0xA5, no error pulses.
- Send 0x3C with stop bit forced 0 → frame_err pulse, rd_valid stays 0.
- Drive a 20-clk low glitch on idle `rx` → no flags, FSM back in IDLE, FIFO empty.
- Send 9 bytes 0x01..0x09 with no reads (FIFO_DEPTH=8):
  - fifo_full=1 after 0x08; 0x09 dropped, overrun=1;
  - popping yields 0x01..0x08; overrun clears on the first pop.
- Keep FIFO full and assert rd_en in the exact push cycle of a new byte 0x55 → count stays 8, overrun stays 0, 0x55 is the last byte read out.
- Assert rst low during data bit 4 of 0xF0, release, then send 0x81 → only 0x81 appears; all outputs 0 while in reset.
- With UART_RX_PARITY_EN: send 0x07 with the parity bit flipped → parity_err pulse, no push.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared states, constants and baud divider helper for the UART receiver
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;
  localparam int DATA_BITS  = 8;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - first-word-fall-through FIFO with wrap-bit pointers
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 16x oversampling UART receiver feeding a FWFT byte FIFO
// Optional even parity bit enabled by UART_RX_PARITY_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       fifo_full,
  output logic       rx_done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int              DIV       = calc_div(CLK_FREQ, BAUD);
  localparam int              TW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(DIV - 1);
  localparam logic [3:0]      S_LAST    = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      S_A       = 4'(SAMPLE_MID - 1);
  localparam logic [3:0]      S_B       = 4'(SAMPLE_MID);
  localparam logic [3:0]      S_C       = 4'(SAMPLE_MID + 1);
  localparam logic [2:0]      BIT_LAST  = 3'(DATA_BITS - 1);

  rx_state_t r_state;
  rx_state_t w_next;

  logic          r_rx_meta;
  logic          r_rx_sync;
  logic          r_rx_prev;
  logic [TW-1:0] r_tick_cnt;
  logic [3:0]    r_samp;
  logic [2:0]    r_bit_idx;
  logic          r_v7;
  logic          r_v8;
  logic          r_bit;
  logic [7:0]    r_shift;
  logic          r_push_req;
  logic          r_frame_err;
  logic          r_overrun;

  logic          w_fall;
  logic          w_tick;
  logic          w_samp_last;
  logic          w_stop_decide;
  logic          w_maj;
  logic          w_parity_bad;
  logic          w_empty;
  logic          w_pop;
  logic          w_drop;

  assign w_fall        = r_rx_prev & ~r_rx_sync;
  assign w_tick        = (r_state != IDLE) && (r_tick_cnt == TICK_LAST);
  assign w_samp_last   = w_tick && (r_samp == S_LAST);
  assign w_stop_decide = w_tick && (r_state == STOP) && (r_samp == S_C);
  assign w_maj         = (r_v7 & r_v8) | (r_v7 & r_rx_sync) | (r_v8 & r_rx_sync);

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;
  assign w_parity_bad = ^{r_shift, r_par_bit};
  assign parity_err   = r_parity_err;
`else
  assign w_parity_bad = 1'b0;
  assign parity_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (w_fall) w_next = START;
      START: if (w_samp_last) w_next = r_bit ? IDLE : DATA;
      DATA: begin
        if (w_samp_last && (r_bit_idx == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_next = PARITY;
`else
          w_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (w_samp_last) w_next = STOP;
`endif
      // Returning at sample 9 lets a following start edge in samples 10..15 be caught.
      STOP:  if (w_stop_decide) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_tick_cnt  <= '0;
      r_samp      <= '0;
      r_bit_idx   <= '0;
      r_v7        <= 1'b1;
      r_v8        <= 1'b1;
      r_bit       <= 1'b1;
      r_shift     <= '0;
      r_push_req  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= rx;
      r_rx_sync   <= r_rx_meta;
      r_rx_prev   <= r_rx_sync;
      r_push_req  <= 1'b0;
      r_frame_err <= 1'b0;

      // Counters rest at zero in IDLE, which also clears them on start detection.
      if (r_state == IDLE) begin
        r_tick_cnt <= '0;
        r_samp     <= '0;
        r_bit_idx  <= '0;
      end else begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        if (w_tick) begin
          r_samp <= r_samp + 1'b1;
          if (r_samp == S_A) r_v7  <= r_rx_sync;
          if (r_samp == S_B) r_v8  <= r_rx_sync;
          if (r_samp == S_C) r_bit <= w_maj;
        end
        if (w_samp_last && (r_state == DATA)) begin
          r_shift   <= {r_bit, r_shift[7:1]};
          r_bit_idx <= r_bit_idx + 1'b1;
        end
      end

      if (w_stop_decide) begin
        if (!w_maj)             r_frame_err <= 1'b1;
        else if (!w_parity_bad) r_push_req  <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= w_stop_decide && w_maj && w_parity_bad;
      if (w_samp_last && (r_state == PARITY)) r_par_bit <= r_bit;
    end
  end
`endif

  assign w_pop  = rd_en & ~w_empty;
  assign w_drop = r_push_req & fifo_full & ~w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_overrun <= 1'b0;
    else if (w_drop) r_overrun <= 1'b1;
    else if (w_pop)  r_overrun <= 1'b0;
  end

  uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push_req),
    .i_wdata (r_shift),
    .i_pop   (rd_en),
    .o_rdata (rd_data),
    .o_full  (fifo_full),
    .o_empty (w_empty)
  );

  assign rd_valid  = ~w_empty;
  assign rx_done   = r_push_req & ~w_drop;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo (honours UART_RX_PARITY_EN)
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int CLK_FREQ = 7_372_800;
  localparam int BAUD     = 115200;
  localparam int DEPTH    = 8;
  localparam int BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif
  // Posedge (counted from the start-bit edge) that registers the push request.
  localparam int PUSH_EDGE = 3 + 4 * (16 * STOP_IDX + 10);

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       fifo_full;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int base_done;
  int base_ferr;
  int base_perr;

  uart_rx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_full  (fifo_full),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (rx_done)    n_done++;
    if (frame_err)  n_ferr++;
    if (parity_err) n_perr++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_v, input logic par_flip);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (BIT_CLKS) @(negedge clk);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_v;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check(tag, {23'd0, rd_valid, rd_data}, {23'd0, 1'b1, exp});
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    rx    = 1'b1;
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {24'd0, rd_data, rd_valid, fifo_full, rx_done, frame_err, parity_err, overrun}, 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // Single good byte
    send_byte(8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("a5_done_cnt", n_done, 1);
    check("a5_no_ferr", n_ferr, 0);
    check("a5_no_perr", n_perr, 0);
    pop_check("a5_data", 8'hA5);
    check("a5_drained", rd_valid, 1'b0);

    // Stop bit forced low
    send_byte(8'h3C, 1'b0, 1'b0);
    repeat (100) @(negedge clk);
    check("3c_ferr_cnt", n_ferr, 1);
    check("3c_no_push", {rd_valid, 31'(n_done)}, {1'b0, 31'd1});

    // 20-clk glitch on idle line
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_flags", {n_done[7:0], n_ferr[7:0], n_perr[7:0]}, {8'd1, 8'd1, 8'd0});
    check("glitch_idle", 32'(dut.r_state), 32'(IDLE));
    check("glitch_empty", rd_valid, 1'b0);

    // Nine back-to-back bytes, no reads
    base_done = n_done;
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("fill8_full", {fifo_full, overrun}, {1'b1, 1'b0});
    send_byte(8'h09, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("ovr_set", {fifo_full, overrun}, {1'b1, 1'b1});
    check("ovr_done_cnt", n_done - base_done, 8);
    pop_check("ovr_pop1", 8'h01);
    check("ovr_clear", overrun, 1'b0);
    for (int i = 2; i <= 8; i++) pop_check("ovr_pop", 8'(i));
    check("ovr_drained", rd_valid, 1'b0);

    // Push and pop in the same cycle while full
    for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), 1'b1, 1'b0);
    base_done = n_done;
    fork
      send_byte(8'h55, 1'b1, 1'b0);
      begin
        @(negedge clk);
        repeat (PUSH_EDGE) @(posedge clk);
        @(negedge clk);
        rd_en = 1'b1;
        #1;
        check("sim_rx_done", {rx_done, fifo_full}, {1'b1, 1'b1});
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("sim_state", {fifo_full, overrun}, {1'b1, 1'b0});
    check("sim_done_cnt", n_done - base_done, 1);
    for (int i = 1; i < 8; i++) pop_check("sim_pop", 8'h11 + 8'(i));
    pop_check("sim_last", 8'h55);
    check("sim_drained", rd_valid, 1'b0);

    // Reset during data bit 4 of 0xF0
    send_byte(8'hC3, 1'b1, 1'b0);
    base_done = n_done;
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_outs", {24'd0, rd_data, rd_valid, fifo_full, rx_done, frame_err, parity_err, overrun}, 32'd0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    send_byte(8'h81, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("rst_done_cnt", n_done - base_done, 1);
    pop_check("rst_data", 8'h81);
    check("rst_drained", rd_valid, 1'b0);

`ifdef UART_RX_PARITY_EN
    base_perr = n_perr;
    base_done = n_done;
    send_byte(8'h07, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("par_err_cnt", n_perr - base_perr, 1);
    check("par_no_push", {rd_valid, 31'(n_done - base_done)}, 32'd0);
`else
    base_perr = n_perr;
    base_ferr = n_ferr;
    send_byte(8'h07, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("nopar_flags", {16'(n_perr - base_perr), 16'(n_ferr - base_ferr)}, 32'd0);
    pop_check("nopar_data", 8'h07);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
